ttl_74ls193_sync: RTL

- Synchronous FPGA model of a cascaded 74LS193 presettable 4-bit binary up/down counter chain.
- It is the counterpart to the up-only ripple counters already in the TTL library: it supports count-down, parallel preset, and carry/borrow generation.
- The TTL UP/DN count lines are treated as ordinary signals. They are synchronized and edge-detected in the system clock domain, so every register sits on clk.
- It replaces board-level 193 chains used for DMA/refresh/timer address counting.

---
 rtl/ttl_74ls193_sync_if.sv | 24 ++
 rtl/ttl_74ls193_sync.sv | 79 +++++++
 2 files changed

// File: rtl/ttl_74ls193_sync_if.sv
// Bus bundle for the synchronous 74LS193 counter chain: count lines, preset/clear
// controls and preset data in, counter value and terminal-count flags out.
interface ttl_74ls193_sync_if #(
   parameter int W = 8
);
   logic         up;
   logic         dn;
   logic         load_n;
   logic         clr;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic         co_n;
   logic         bo_n;

   modport master (
      output up, dn, load_n, clr, d,
      input  q, co_n, bo_n
   );

   modport slave (
      input  up, dn, load_n, clr, d,
      output q, co_n, bo_n
   );
endinterface

// File: rtl/ttl_74ls193_sync.sv
// Cascaded 74LS193 up/down counter re-timed onto one system clock: the TTL count
// lines are synchronized and edge-detected, so every flop sits on clk.
module ttl_74ls193_sync #(
   parameter int STAGES      = 2,
   parameter int SYNC_STAGES = 2
) (
   input  logic              clk,
   input  logic              reset_n,
   ttl_74ls193_sync_if.slave bus
);
   localparam int W = 4 * STAGES;
   localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

   logic [SYNC_STAGES-1:0] up_sync_q;
   logic [SYNC_STAGES-1:0] dn_sync_q;
   logic [SYNC_STAGES-1:0] ld_sync_q;
   logic [SYNC_STAGES-1:0] clr_sync_q;
   logic                   up_prev_q;
   logic                   dn_prev_q;
   logic [W-1:0]           q_q;
   logic [W-1:0]           q_d;

   logic us, ds, ls_n, cs;
   logic up_rise, dn_rise;

   assign us   = up_sync_q[SYNC_STAGES-1];
   assign ds   = dn_sync_q[SYNC_STAGES-1];
   assign ls_n = ld_sync_q[SYNC_STAGES-1];
   assign cs   = clr_sync_q[SYNC_STAGES-1];

   assign up_rise = us & ~up_prev_q;
   assign dn_rise = ds & ~dn_prev_q;

   // Next count: clear beats load, load beats counting, simultaneous edges cancel.
   always_comb begin
      q_d = q_q;
      if (cs) begin
         q_d = '0;
      end else if (!ls_n) begin
         q_d = bus.d;
      end else if (up_rise && ds && !dn_rise) begin
         q_d = q_q + ONE;
      end else if (dn_rise && us && !up_rise) begin
         q_d = q_q - ONE;
      end
   end

   // Count lines reset high so a line idling high through reset yields no edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         up_sync_q  <= '1;
         dn_sync_q  <= '1;
         ld_sync_q  <= '1;
         clr_sync_q <= '0;
         up_prev_q  <= 1'b1;
         dn_prev_q  <= 1'b1;
         q_q        <= '0;
      end else begin
         up_sync_q[0]  <= bus.up;
         dn_sync_q[0]  <= bus.dn;
         ld_sync_q[0]  <= bus.load_n;
         clr_sync_q[0] <= bus.clr;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            up_sync_q[i]  <= up_sync_q[i-1];
            dn_sync_q[i]  <= dn_sync_q[i-1];
            ld_sync_q[i]  <= ld_sync_q[i-1];
            clr_sync_q[i] <= clr_sync_q[i-1];
         end
         up_prev_q <= us;
         dn_prev_q <= ds;
         q_q       <= q_d;
      end
   end

   // Terminal-count flags pulse low while the relevant count line is low.
   assign bus.q    = q_q;
   assign bus.co_n = ~((q_q == '1) & ~us);
   assign bus.bo_n = ~((q_q == '0) & ~ds);
endmodule
